chat_session_ctrl: RTL and testbench

Session controller for the two-user chat terminal: owns the display state (LOGIN, PASSWORD, SENDING, RECEIVING) and sequences the shared LCD, GPIO link and audio chime from decoded PS2 keys and link events. It sits between key2ascii/ps2_keyboard and the lcd, gpio_protocol and audio paths. It replaces ad-hoc top-level state logic with multi-character password entry, an idle timeout and a send handshake.

---
 rtl/chat_pkg.sv | 30 +++
 rtl/pass_entry_buffer.sv | 59 +++++
 rtl/chat_session_ctrl.sv | 147 ++++++++++++++
 tb/tb_chat_session_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chat_pkg.sv
// Shared constants for the chat terminal: display-state encoding (LEDR[4:3]), user ids, key codes, passwords.
// No logic or latency here; no flow control.
package chat_pkg;

  localparam logic [1:0] ST_LOGIN     = 2'b00;
  localparam logic [1:0] ST_PASSWORD  = 2'b01;
  localparam logic [1:0] ST_SENDING   = 2'b10;
  localparam logic [1:0] ST_RECEIVING = 2'b11;

  localparam logic [1:0] USER_NONE  = 2'd0;
  localparam logic [1:0] USER_BILLY = 2'd1;
  localparam logic [1:0] USER_BOB   = 2'd2;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_ENTER = 8'h0D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;
  localparam logic [7:0] ASCII_2     = 8'h32;

  localparam int PASS_LEN_DEF = 4;

  // First typed character sits in the most significant byte.
  localparam logic [8*PASS_LEN_DEF-1:0] PASS_BILLY = "0420";
  localparam logic [8*PASS_LEN_DEF-1:0] PASS_BOB   = "1337";

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/pass_entry_buffer.sv
// Password entry storage: PASS_LEN chars, write index, overflow flag, match against the selected password.
// Updates one cycle after push/pop/clear, match is combinational from state; no backpressure, every command is taken.
module pass_entry_buffer
  import chat_pkg::*;
#(
  parameter int PASS_LEN = PASS_LEN_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            push_char,
  input  logic [8*PASS_LEN-1:0] password,
  output logic                  match
);

  localparam int IW = $clog2(PASS_LEN + 1);

  logic [7:0]    buf_q [PASS_LEN];
  logic [IW-1:0] idx_q;
  logic          ovf_q;
  logic          chars_eq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < PASS_LEN; i++) buf_q[i] <= 8'h00;
    end else if (clear) begin
      idx_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < PASS_LEN; i++) buf_q[i] <= 8'h00;
    end else if (push) begin
      if (idx_q == IW'(PASS_LEN)) begin
        ovf_q <= 1'b1;
      end else begin
        for (int i = 0; i < PASS_LEN; i++)
          if (idx_q == IW'(i)) buf_q[i] <= push_char;
        idx_q <= idx_q + IW'(1);
      end
    end else if (pop) begin
      // A backspace after overflow only discards the excess keys; stored chars stay.
      if (ovf_q)
        ovf_q <= 1'b0;
      else if (idx_q != '0)
        idx_q <= idx_q - IW'(1);
    end
  end

  always_comb begin
    chars_eq = 1'b1;
    for (int i = 0; i < PASS_LEN; i++)
      if (buf_q[i] != password[8*(PASS_LEN-1-i) +: 8]) chars_eq = 1'b0;
  end

  assign match = chars_eq && !ovf_q && (idx_q == IW'(PASS_LEN));

endmodule

// File: rtl/chat_session_ctrl.sv
// Chat session controller: login/password/send/receive state, idle logout, chime and send handshake.
// Registered outputs one cycle after the key/event (lcd_echo_en is combinational); no backpressure, pulses always taken.
module chat_session_ctrl
  import chat_pkg::*;
#(
  parameter int          PASS_LEN     = PASS_LEN_DEF,
  parameter logic [31:0] IDLE_TIMEOUT = 32'd1_500_000_000,
  parameter logic [31:0] CHIME_CYCLES = 32'd25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic       logout,
  input  logic       link_received,
  input  logic       link_done,
  output logic [1:0] display_state,
  output logic [1:0] user_id,
  output logic       send_req,
  output logic       lcd_refresh,
  output logic       lcd_echo_en,
  output logic       auth_fail,
  output logic       chime
);

  localparam logic [8*PASS_LEN-1:0] PW_BILLY = (8*PASS_LEN)'(PASS_BILLY);
  localparam logic [8*PASS_LEN-1:0] PW_BOB   = (8*PASS_LEN)'(PASS_BOB);

  logic [31:0] idle_cnt;
  logic [31:0] chime_cnt;
  logic [1:0]  state_nxt;
  logic [1:0]  user_nxt;
  logic        send_nxt;
  logic        fail_nxt;
  logic        is_enter;
  logic        is_bs;
  logic        timeout;
  logic        force_out;
  logic        key_act;
  logic        buf_push;
  logic        buf_pop;
  logic        buf_clear;
  logic        pw_match;
  logic [8*PASS_LEN-1:0] pw_sel;

  assign is_enter  = (key_ascii == ASCII_ENTER);
  assign is_bs     = (key_ascii == ASCII_BS);
  assign timeout   = (display_state != ST_LOGIN) && (idle_cnt == IDLE_TIMEOUT - 32'd1);
  assign force_out = logout || timeout;
  // Keys lose to any link event landing in the same cycle.
  assign key_act   = key_valid && !force_out && !link_received && !link_done;
  assign pw_sel    = (user_id == USER_BOB) ? PW_BOB : PW_BILLY;

  assign lcd_echo_en = key_valid && !is_enter && !is_bs &&
                       ((display_state == ST_PASSWORD) || (display_state == ST_SENDING));

  always_comb begin
    state_nxt = display_state;
    user_nxt  = user_id;
    send_nxt  = send_req;
    fail_nxt  = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    if (force_out) begin
      state_nxt = ST_LOGIN;
      user_nxt  = USER_NONE;
      send_nxt  = 1'b0;
    end else begin
      if (link_done) send_nxt = 1'b0;
      if (link_received && display_state == ST_SENDING) state_nxt = ST_RECEIVING;
      if (key_act) begin
        case (display_state)
          ST_LOGIN: begin
            if (key_ascii == ASCII_1) begin
              user_nxt  = USER_BILLY;
              state_nxt = ST_PASSWORD;
            end else if (key_ascii == ASCII_2) begin
              user_nxt  = USER_BOB;
              state_nxt = ST_PASSWORD;
            end
          end
          ST_PASSWORD: begin
            if (is_enter) begin
              if (pw_match) state_nxt = ST_SENDING;
              else          fail_nxt  = 1'b1;
            end else if (is_bs) begin
              buf_pop = 1'b1;
            end else if (is_printable(key_ascii)) begin
              buf_push = 1'b1;
            end
          end
          ST_SENDING: begin
            if (is_enter && !send_req) send_nxt = 1'b1;
          end
          default: begin
            if (is_enter) state_nxt = ST_SENDING;
          end
        endcase
      end
    end
  end

  assign buf_clear = fail_nxt || (display_state == ST_PASSWORD && state_nxt != ST_PASSWORD);

  pass_entry_buffer #(.PASS_LEN(PASS_LEN)) u_pass_buf (
    .clock     (clock),
    .reset     (reset),
    .clear     (buf_clear),
    .push      (buf_push),
    .pop       (buf_pop),
    .push_char (key_ascii),
    .password  (pw_sel),
    .match     (pw_match)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      display_state <= ST_LOGIN;
      user_id       <= USER_NONE;
      send_req      <= 1'b0;
      lcd_refresh   <= 1'b0;
      auth_fail     <= 1'b0;
      idle_cnt      <= '0;
      chime_cnt     <= '0;
    end else begin
      display_state <= state_nxt;
      user_id       <= user_nxt;
      send_req      <= send_nxt;
      lcd_refresh   <= (state_nxt != display_state) || fail_nxt;
      auth_fail     <= fail_nxt;

      if (state_nxt != display_state || key_valid)
        idle_cnt <= '0;
      else if (display_state != ST_LOGIN)
        idle_cnt <= idle_cnt + 32'd1;

      // A logout in the same cycle swallows the arrival; a running chime keeps going.
      if (link_received && !force_out && display_state != ST_LOGIN)
        chime_cnt <= CHIME_CYCLES;
      else if (chime_cnt != '0)
        chime_cnt <= chime_cnt - 32'd1;
    end
  end

  assign chime = (chime_cnt != '0);

endmodule

// File: tb/tb_chat_session_ctrl.sv
// Directed bench for chat_session_ctrl with short idle timeout and chime length.
module tb_chat_session_ctrl;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       logout;
  logic       link_received;
  logic       link_done;
  logic [1:0] display_state;
  logic [1:0] user_id;
  logic       send_req;
  logic       lcd_refresh;
  logic       lcd_echo_en;
  logic       auth_fail;
  logic       chime;

  int checks   = 0;
  int failures = 0;

  chat_session_ctrl #(
    .PASS_LEN     (4),
    .IDLE_TIMEOUT (32'd20),
    .CHIME_CYCLES (32'd8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_ascii     (key_ascii),
    .logout        (logout),
    .link_received (link_received),
    .link_done     (link_done),
    .display_state (display_state),
    .user_id       (user_id),
    .send_req      (send_req),
    .lcd_refresh   (lcd_refresh),
    .lcd_echo_en   (lcd_echo_en),
    .auth_fail     (auth_fail),
    .chime         (chime)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: key is sampled at the next posedge, returns at the following negedge.
  task automatic press(input logic [7:0] c);
    key_valid = 1'b1;
    key_ascii = c;
    @(negedge clock);
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic press_echo(input string tag, input logic [7:0] c, input logic exp_echo);
    key_valid = 1'b1;
    key_ascii = c;
    #1;
    chk(tag, {31'd0, lcd_echo_en}, {31'd0, exp_echo});
    @(negedge clock);
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  task automatic pulse_logout();
    logout = 1'b1;
    @(negedge clock);
    logout = 1'b0;
  endtask

  task automatic pulse_done();
    link_done = 1'b1;
    @(negedge clock);
    link_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    logout = 1'b0;
    link_received = 1'b0;
    link_done = 1'b0;

    #12;
    chk("rst_state", display_state, 2'b00);
    chk("rst_user", user_id, 2'd0);
    chk("rst_send", send_req, 1'b0);
    chk("rst_refresh", lcd_refresh, 1'b0);
    chk("rst_auth", auth_fail, 1'b0);
    chk("rst_chime", chime, 1'b0);
    chk("rst_echo", lcd_echo_en, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Login as bob with the correct password
    press(8'h32);
    chk("bob_state_pw", display_state, 2'b01);
    chk("bob_user", user_id, 2'd2);
    chk("bob_refresh_login", lcd_refresh, 1'b1);
    press(8'h31);
    chk("bob_refresh_char", lcd_refresh, 1'b0);
    press_echo("echo_pw_char", 8'h33, 1'b1);
    type_str("37");
    press_echo("echo_enter", 8'h0D, 1'b0);
    chk("bob_state_send", display_state, 2'b10);
    chk("bob_refresh_send", lcd_refresh, 1'b1);
    chk("bob_no_fail", auth_fail, 1'b0);
    pulse_logout();
    chk("logout_state", display_state, 2'b00);
    chk("logout_user", user_id, 2'd0);
    chk("logout_refresh", lcd_refresh, 1'b1);

    // billy: wrong password then the right one
    press(8'h31);
    chk("billy_user", user_id, 2'd1);
    type_str("0421");
    press(8'h0D);
    chk("wrong_fail", auth_fail, 1'b1);
    chk("wrong_refresh", lcd_refresh, 1'b1);
    chk("wrong_state", display_state, 2'b01);
    press(8'h30);
    chk("fail_is_pulse", auth_fail, 1'b0);
    type_str("420");
    press(8'h0D);
    chk("retry_state", display_state, 2'b10);
    pulse_logout();

    // Overflow rejects; backspace over the excess key accepts
    press(8'h31);
    type_str("04209");
    press(8'h0D);
    chk("ovf_fail", auth_fail, 1'b1);
    chk("ovf_state", display_state, 2'b01);
    type_str("04209");
    press(8'h08);
    press(8'h0D);
    chk("bs_pass_state", display_state, 2'b10);
    chk("bs_pass_nofail", auth_fail, 1'b0);

    // Send handshake
    press(8'h0D);
    chk("send_req_set", send_req, 1'b1);
    chk("send_no_refresh", lcd_refresh, 1'b0);
    press(8'h0D);
    chk("send_req_hold", send_req, 1'b1);
    pulse_done();
    chk("send_req_done", send_req, 1'b0);
    link_done = 1'b1;
    press(8'h0D);
    link_done = 1'b0;
    chk("done_beats_enter", send_req, 1'b0);
    press(8'h0D);
    chk("send_req_again", send_req, 1'b1);
    link_received = 1'b1;
    @(negedge clock);
    link_received = 1'b0;
    chk("recv_state", display_state, 2'b11);
    chk("recv_refresh", lcd_refresh, 1'b1);
    chk("recv_send_kept", send_req, 1'b1);
    chk("chime_c0", chime, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("chime_c%0d", i), chime, 1'b1);
    end
    @(negedge clock);
    chk("chime_end", chime, 1'b0);
    pulse_done();
    chk("recv_done", send_req, 1'b0);
    press(8'h0D);
    chk("recv_enter_state", display_state, 2'b10);
    chk("recv_enter_refresh", lcd_refresh, 1'b1);

    // Idle timeout: state change was sampled at cycle 0 of SENDING
    repeat (19) @(negedge clock);
    chk("idle_c19_state", display_state, 2'b10);
    @(negedge clock);
    chk("idle_c20_state", display_state, 2'b00);
    chk("idle_c20_user", user_id, 2'd0);
    chk("idle_c20_refresh", lcd_refresh, 1'b1);

    press(8'h33);
    chk("login_ignore_state", display_state, 2'b00);
    chk("login_ignore_refresh", lcd_refresh, 1'b0);

    // Key at cycle 15 restarts the idle count
    press(8'h32);
    type_str("1337");
    press(8'h0D);
    chk("idle2_state", display_state, 2'b10);
    repeat (15) @(negedge clock);
    press_echo("echo_sending", 8'h61, 1'b1);
    repeat (4) @(negedge clock);
    chk("idle2_c20_state", display_state, 2'b10);
    repeat (15) @(negedge clock);
    chk("idle2_c35_state", display_state, 2'b10);
    @(negedge clock);
    chk("idle2_c36_state", display_state, 2'b00);

    pulse_logout();
    chk("logout_in_login_refresh", lcd_refresh, 1'b0);
    chk("logout_in_login_state", display_state, 2'b00);

    // logout beats link_received
    press(8'h32);
    type_str("1337");
    press(8'h0D);
    logout = 1'b1;
    link_received = 1'b1;
    @(negedge clock);
    logout = 1'b0;
    link_received = 1'b0;
    chk("logout_vs_recv_state", display_state, 2'b00);
    chk("logout_vs_recv_user", user_id, 2'd0);

    // Asynchronous reset during password entry, with a refresh pulse pending
    press(8'h31);
    chk("pre_rst_refresh", lcd_refresh, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("arst_state", display_state, 2'b00);
    chk("arst_user", user_id, 2'd0);
    chk("arst_refresh", lcd_refresh, 1'b0);
    chk("arst_send", send_req, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rel_refresh", lcd_refresh, 1'b0);
    chk("rel_state", display_state, 2'b00);
    chk("rel_auth", auth_fail, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
